// File: rtl/ram_1r1w_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_1r1w_pipe_if                                              |
// | Description : Write/read bus bundle for ram_1r1w_pipe.                      |
// |               master drives requests; slave (the RAM) returns read data.    |
// | Signals     : wr_valid_i/wr_mask_i/wr_addr_i/wr_data_i  write request       |
// |               rd_valid_i/rd_addr_i                      read request        |
// |               rd_valid_o/rd_data_o                      read result         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface ram_1r1w_pipe_if #(
  parameter int width_p      = 16,
  parameter int depth_p      = 512,
  parameter int lane_width_p = 8
);
  localparam int c_lanes = width_p / lane_width_p;
  localparam int c_aw    = (depth_p > 1) ? $clog2(depth_p) : 1;

  logic                 wr_valid_i;
  logic [c_lanes-1:0]   wr_mask_i;
  logic [c_aw-1:0]      wr_addr_i;
  logic [width_p-1:0]   wr_data_i;
  logic                 rd_valid_i;
  logic [c_aw-1:0]      rd_addr_i;
  logic                 rd_valid_o;
  logic [width_p-1:0]   rd_data_o;

  modport master (
    output wr_valid_i, wr_mask_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
    input  rd_valid_o, rd_data_o
  );

  modport slave (
    input  wr_valid_i, wr_mask_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
    output rd_valid_o, rd_data_o
  );
endinterface
`default_nettype wire

// File: rtl/ram_1r1w_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_1r1w_pipe                                                 |
// | Description : One-write/one-read synchronous RAM with lane-masked writes,   |
// |               1- or 2-cycle read latency, optional write-first forwarding   |
// |               and a hardware sweep that zeroes every entry.                 |
// | Ports       : clk_i    clock, rising edge                                   |
// |               reset_i  asynchronous, active-low reset                       |
// |               clear_i  start a zeroing sweep (sampled in IDLE only)         |
// |               busy_o   sweep in progress, bus requests ignored              |
// |               bus      ram_1r1w_pipe_if.slave write/read bundle             |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module ram_1r1w_pipe #(
  parameter int width_p      = 16,
  parameter int depth_p      = 512,
  parameter int lane_width_p = 8,
  parameter int rd_latency_p = 1,
  parameter int bypass_p     = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  ram_1r1w_pipe_if.slave       bus
);

  localparam int              c_lanes = width_p / lane_width_p;
  localparam int              c_aw    = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam logic [c_aw-1:0] c_last  = c_aw'(depth_p - 1);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(depth_p);

  generate
    if ((width_p % lane_width_p) != 0) begin : g_bad_width
      $error("ram_1r1w_pipe: width_p must be a multiple of lane_width_p");
    end
  endgenerate

  // ---------------------------------------------------------------- clear FSM
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [c_aw-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (clear_i) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if (r_cnt == c_last) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Decode of the state register only; clear_i has no direct path to busy_o.
  assign busy_o = (r_state == S_CLEAR);

  // ------------------------------------------------------------- array access
  logic w_wr_en, w_rd_en, w_wr_in_range, w_rd_in_range;

  assign w_wr_in_range = ({1'b0, bus.wr_addr_i} < c_depth);
  assign w_rd_in_range = ({1'b0, bus.rd_addr_i} < c_depth);
  assign w_wr_en       = bus.wr_valid_i & ~busy_o & w_wr_in_range;
  assign w_rd_en       = bus.rd_valid_i & ~busy_o;

  logic [width_p-1:0] r_mem [depth_p];

  // The sweep owns the array while busy, so port writes never compete with it.
  always_ff @(posedge clk_i) begin
    if (busy_o) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int l = 0; l < c_lanes; l++) begin
        if (bus.wr_mask_i[l]) begin
          r_mem[bus.wr_addr_i][l*lane_width_p +: lane_width_p] <=
            bus.wr_data_i[l*lane_width_p +: lane_width_p];
        end
      end
    end
  end

  // Out-of-range reads return zero; with forwarding, lanes being written on
  // this same edge are taken from the write bus instead of the stale array.
  logic [width_p-1:0] w_rd_data;

  always_comb begin
    w_rd_data = '0;
    if (w_rd_in_range) begin
      w_rd_data = r_mem[bus.rd_addr_i];
      if ((bypass_p != 0) && w_wr_en && (bus.wr_addr_i == bus.rd_addr_i)) begin
        for (int l = 0; l < c_lanes; l++) begin
          if (bus.wr_mask_i[l]) begin
            w_rd_data[l*lane_width_p +: lane_width_p] =
              bus.wr_data_i[l*lane_width_p +: lane_width_p];
          end
        end
      end
    end
  end

  // ----------------------------------------------------------- read pipeline
  logic               r_rd_v1;
  logic [width_p-1:0] r_rd_d1;

  // Data registers load only on a valid so the output holds between reads.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_v1 <= 1'b0;
      r_rd_d1 <= '0;
    end else begin
      r_rd_v1 <= w_rd_en;
      if (w_rd_en) begin
        r_rd_d1 <= w_rd_data;
      end
    end
  end

  generate
    if (rd_latency_p == 1) begin : g_lat1
      assign bus.rd_valid_o = r_rd_v1;
      assign bus.rd_data_o  = r_rd_d1;
    end else if (rd_latency_p == 2) begin : g_lat2
      logic               r_rd_v2;
      logic [width_p-1:0] r_rd_d2;

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          r_rd_v2 <= 1'b0;
          r_rd_d2 <= '0;
        end else begin
          r_rd_v2 <= r_rd_v1;
          if (r_rd_v1) begin
            r_rd_d2 <= r_rd_d1;
          end
        end
      end

      assign bus.rd_valid_o = r_rd_v2;
      assign bus.rd_data_o  = r_rd_d2;
    end else begin : g_bad_latency
      $error("ram_1r1w_pipe: rd_latency_p must be 1 or 2");
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_1r1w_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ram_1r1w_pipe                                              |
// | Description : Directed self-checking bench for ram_1r1w_pipe. Two 16-entry  |
// |               builds (A: latency 1 + forwarding, B: latency 2 + read-first) |
// |               share one stimulus; build C is a 12-entry latency-1 RAM.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ram_1r1w_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic busy_a, busy_b, busy_c;
  logic c_clr;

  always #5 clk = ~clk;

  // shared stimulus for A and B
  logic        wr_valid;
  logic [1:0]  wr_mask;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic [3:0]  rd_addr;

  // stimulus for C
  logic        c_wr_valid;
  logic [1:0]  c_wr_mask;
  logic [3:0]  c_wr_addr;
  logic [15:0] c_wr_data;
  logic        c_rd_valid;
  logic [3:0]  c_rd_addr;

  ram_1r1w_pipe_if #(.width_p(16), .depth_p(16), .lane_width_p(8)) ifa ();
  ram_1r1w_pipe_if #(.width_p(16), .depth_p(16), .lane_width_p(8)) ifb ();
  ram_1r1w_pipe_if #(.width_p(16), .depth_p(12), .lane_width_p(8)) ifc ();

  assign ifa.wr_valid_i = wr_valid;
  assign ifa.wr_mask_i  = wr_mask;
  assign ifa.wr_addr_i  = wr_addr;
  assign ifa.wr_data_i  = wr_data;
  assign ifa.rd_valid_i = rd_valid;
  assign ifa.rd_addr_i  = rd_addr;
  assign ifb.wr_valid_i = wr_valid;
  assign ifb.wr_mask_i  = wr_mask;
  assign ifb.wr_addr_i  = wr_addr;
  assign ifb.wr_data_i  = wr_data;
  assign ifb.rd_valid_i = rd_valid;
  assign ifb.rd_addr_i  = rd_addr;
  assign ifc.wr_valid_i = c_wr_valid;
  assign ifc.wr_mask_i  = c_wr_mask;
  assign ifc.wr_addr_i  = c_wr_addr;
  assign ifc.wr_data_i  = c_wr_data;
  assign ifc.rd_valid_i = c_rd_valid;
  assign ifc.rd_addr_i  = c_rd_addr;

  ram_1r1w_pipe #(.width_p(16), .depth_p(16), .lane_width_p(8),
                  .rd_latency_p(1), .bypass_p(1)) u_dut_a (
    .clk_i(clk), .reset_i(rst_n), .clear_i(clr), .busy_o(busy_a), .bus(ifa.slave));

  ram_1r1w_pipe #(.width_p(16), .depth_p(16), .lane_width_p(8),
                  .rd_latency_p(2), .bypass_p(0)) u_dut_b (
    .clk_i(clk), .reset_i(rst_n), .clear_i(clr), .busy_o(busy_b), .bus(ifb.slave));

  ram_1r1w_pipe #(.width_p(16), .depth_p(12), .lane_width_p(8),
                  .rd_latency_p(1), .bypass_p(1)) u_dut_c (
    .clk_i(clk), .reset_i(rst_n), .clear_i(c_clr), .busy_o(busy_c), .bus(ifc.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    tick();
    wr_valid = 1'b0;
  endtask

  // Read one address on A and B; A answers after one edge, B after two.
  task automatic rd_chk(input logic [3:0] a, input logic [15:0] ea,
                        input logic [15:0] eb, input string tag);
    rd_valid = 1'b1; rd_addr = a;
    tick();
    rd_valid = 1'b0;
    chk_vec({tag, " A valid"}, 32'(ifa.rd_valid_o), 32'd1);
    chk_vec({tag, " A data"},  32'(ifa.rd_data_o),  32'(ea));
    chk_vec({tag, " B early valid"}, 32'(ifb.rd_valid_o), 32'd0);
    tick();
    chk_vec({tag, " B valid"}, 32'(ifb.rd_valid_o), 32'd1);
    chk_vec({tag, " B data"},  32'(ifb.rd_data_o),  32'(eb));
    chk_vec({tag, " A valid drop"}, 32'(ifa.rd_valid_o), 32'd0);
    chk_vec({tag, " A data hold"},  32'(ifa.rd_data_o),  32'(ea));
  endtask

  task automatic wrc(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    c_wr_valid = 1'b1; c_wr_addr = a; c_wr_data = d; c_wr_mask = m;
    tick();
    c_wr_valid = 1'b0;
  endtask

  task automatic rdc(input logic [3:0] a, input logic [15:0] e, input string tag);
    c_rd_valid = 1'b1; c_rd_addr = a;
    tick();
    c_rd_valid = 1'b0;
    chk_vec({tag, " C valid"}, 32'(ifc.rd_valid_o), 32'd1);
    chk_vec({tag, " C data"},  32'(ifc.rd_data_o),  32'(e));
    tick();
    chk_vec({tag, " C valid drop"}, 32'(ifc.rd_valid_o), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_vec({tag, " A valid"}, 32'(ifa.rd_valid_o), 32'd0);
    chk_vec({tag, " A data"},  32'(ifa.rd_data_o),  32'd0);
    chk_vec({tag, " A busy"},  32'(busy_a),         32'd0);
    chk_vec({tag, " B valid"}, 32'(ifb.rd_valid_o), 32'd0);
    chk_vec({tag, " B data"},  32'(ifb.rd_data_o),  32'd0);
    chk_vec({tag, " B busy"},  32'(busy_b),         32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] e;
    rst_n = 1'b0; clr = 1'b0; c_clr = 1'b0;
    wr_valid = 1'b0; wr_mask = '0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;
    c_wr_valid = 1'b0; c_wr_mask = '0; c_wr_addr = '0; c_wr_data = '0;
    c_rd_valid = 1'b0; c_rd_addr = '0;
    tick(); tick();
    chk_reset_outputs("reset");
    chk_vec("reset C busy", 32'(busy_c), 32'd0);
    rst_n = 1'b1;
    tick();

    // latency 1 vs 2
    wr(4'd5, 16'hBEEF, 2'b11);
    rd_chk(4'd5, 16'hBEEF, 16'hBEEF, "latency");

    // asynchronous reset clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async reset");
    rst_n = 1'b1;
    tick();

    // masked write
    wr(4'd7, 16'h1234, 2'b11);
    wr(4'd7, 16'hABCD, 2'b10);
    rd_chk(4'd7, 16'hAB34, 16'hAB34, "mask");

    // same-edge collision: A forwards, B returns old data
    wr(4'd3, 16'h0000, 2'b11);
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 16'h5A5A; wr_mask = 2'b01;
    rd_valid = 1'b1; rd_addr = 4'd3;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk_vec("collide A data", 32'(ifa.rd_data_o), 32'h005A);
    tick();
    chk_vec("collide B data", 32'(ifb.rd_data_o), 32'h0000);
    rd_chk(4'd3, 16'h005A, 16'h005A, "after collide");

    // clear sweep: busy for exactly 16 cycles, requests ignored
    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk_vec($sformatf("sweep busy A c%0d", k), 32'(busy_a), 32'd1);
      chk_vec($sformatf("sweep busy B c%0d", k), 32'(busy_b), 32'd1);
      chk_vec($sformatf("sweep rdv A c%0d", k), 32'(ifa.rd_valid_o), 32'd0);
      chk_vec($sformatf("sweep rdv B c%0d", k), 32'(ifb.rd_valid_o), 32'd0);
      if (k == 10) begin
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 16'h1111; wr_mask = 2'b11;
        rd_valid = 1'b1; rd_addr = 4'd2;
      end
      tick();
      wr_valid = 1'b0; rd_valid = 1'b0;
    end
    chk_vec("sweep end busy A", 32'(busy_a), 32'd0);
    chk_vec("sweep end busy B", 32'(busy_b), 32'd0);
    chk_vec("sweep end rdv B", 32'(ifb.rd_valid_o), 32'd0);
    for (int i = 0; i < 16; i++)
      rd_chk(4'(i), 16'h0000, 16'h0000, $sformatf("swept %0d", i));

    // reset after 6 busy cycles: entries 0..5 zero, 6..15 untouched
    for (int i = 0; i < 16; i++) wr(4'(i), 16'hFFFF, 2'b11);
    rd_chk(4'd0, 16'hFFFF, 16'hFFFF, "prefill");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (6) tick();
    chk_vec("midclear busy before reset", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midclear reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      e = (i < 6) ? 16'h0000 : 16'hFFFF;
      rd_chk(4'(i), e, e, $sformatf("partial %0d", i));
    end

    // streaming: 8 back-to-back reads
    for (int k = 0; k < 8; k++) wr(4'(8 + k), 16'hC000 + 16'(k) * 16'h0101, 2'b11);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        rd_valid = 1'b1; rd_addr = 4'(8 + i);
      end else begin
        rd_valid = 1'b0;
      end
      tick();
      if (i < 8) begin
        chk_vec($sformatf("stream A valid %0d", i), 32'(ifa.rd_valid_o), 32'd1);
        chk_vec($sformatf("stream A data %0d", i), 32'(ifa.rd_data_o),
                32'(16'hC000 + 16'(i) * 16'h0101));
      end else begin
        chk_vec($sformatf("stream A idle %0d", i), 32'(ifa.rd_valid_o), 32'd0);
      end
      if (i >= 1 && i < 9) begin
        chk_vec($sformatf("stream B valid %0d", i), 32'(ifb.rd_valid_o), 32'd1);
        chk_vec($sformatf("stream B data %0d", i), 32'(ifb.rd_data_o),
                32'(16'hC000 + 16'(i - 1) * 16'h0101));
      end else begin
        chk_vec($sformatf("stream B idle %0d", i), 32'(ifb.rd_valid_o), 32'd0);
      end
    end
    rd_valid = 1'b0;

    // 12-entry build: out-of-range read/write
    for (int i = 0; i < 12; i++) wrc(4'(i), 16'h0A00 + 16'(i), 2'b11);
    rdc(4'd13, 16'h0000, "oob read");
    wrc(4'd13, 16'hDEAD, 2'b11);
    rdc(4'd13, 16'h0000, "oob read after write");
    for (int i = 0; i < 12; i++)
      rdc(4'(i), 16'h0A00 + 16'(i), $sformatf("oob keep %0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_1r1w_pipe.md
Name: ram_1r1w_pipe

Overview:
Parametrised successor to the single-port-pair synchronous RAM: one write port and one read port, one clock.
- Adds lane-masked writes and a selectable read latency of 1 or 2 cycles with an output valid.
- Adds optional same-address write-to-read forwarding and a hardware clear sequencer.
- Serves as a sample/coefficient store in the tuner datapath, where the sequencer zeroes memory without host writes.

Parameters:
width_p, 16, data word width in bits; must be a multiple of lane_width_p.
depth_p, 512, number of words; need not be a power of two.
lane_width_p, 8, bits per write-mask lane; lanes_lp = width_p/lane_width_p.
rd_latency_p, 1, read latency in cycles; legal values 1 or 2, anything else is an elaboration error.
bypass_p, 1, 1 = write-first forwarding on address collision, 0 = read-first (old data).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
reset_i  in  1  asynchronous, active-low reset (0 = reset).
clear_i  in  1  request to zero all depth_p entries.
busy_o  out  1  clear sweep in progress; ports ignored while high.
wr_valid_i  in  1  write request.
wr_mask_i  in  lanes_lp  per-lane write enable.
wr_addr_i  in  $clog2(depth_p)  write address.
wr_data_i  in  width_p  write data.
rd_valid_i  in  1  read request.
rd_addr_i  in  $clog2(depth_p)  read address.
rd_valid_o  out  1  rd_data_o holds the result of a read issued rd_latency_p cycles earlier.
rd_data_o  out  width_p  read data.

Behaviour:
- Reset (reset_i=0, asynchronous): rd_valid_o=0, rd_data_o=0, busy_o=0, FSM=IDLE, sweep counter=0, pipeline valids=0. Array contents are not reset.
- Write: on an edge with wr_valid_i=1, busy_o=0 and wr_addr_i<depth_p, each lane l with wr_mask_i[l]=1 takes wr_data_i lane l. Unmasked lanes keep their value. Mask all-zero is a no-op.
- Write with wr_addr_i>=depth_p is dropped silently.
- Read: accepted on an edge with rd_valid_i=1 and busy_o=0.
  - rd_latency_p=1: data and rd_valid_o=1 appear after that edge.
  - rd_latency_p=2: an extra output register delays data and valid by one more edge.
  - rd_valid_o is high for exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
- Out-of-range read (rd_addr_i>=depth_p) returns all zeros with rd_valid_o=1.
- rd_data_o holds its last value when rd_valid_o=0; it is not zeroed.
- Collision (read and write to the same address on the same edge):
  - bypass_p=1: masked lanes return wr_data_i, unmasked lanes return old contents.
  - bypass_p=0: all lanes return old contents.
- Clear FSM, IDLE state: busy_o=0. clear_i=1 moves to CLEAR with counter=0.
  - Reads and writes presented on the same edge as clear_i are still performed.
  - Any data written on that edge is later overwritten by the sweep.
- Clear FSM, CLEAR state: busy_o=1.
  - Each cycle writes zeros to entry counter, then counter increments.
  - After entry depth_p-1 is written, return to IDLE. busy_o is high for exactly depth_p cycles.
  - clear_i, wr_valid_i and rd_valid_i are ignored; no rd_valid_o is generated for requests made during CLEAR.
  - Reads accepted before CLEAR still complete through the pipeline.
- Reset mid-clear: immediate return to IDLE; already-swept entries stay zero, the rest are untouched.
- busy_o is a registered state decode (no combinational path from clear_i).

Test Plan:
1. Latency and reset: rd_latency_p=1, write 0xBEEF to addr 5 with mask 2'b11, read addr 5 -> rd_valid_o=1 with 0xBEEF one cycle after the read edge. Repeat with rd_latency_p=2 -> result two cycles later. Drive reset_i low at any point -> rd_valid_o=0, rd_data_o=0, busy_o=0 immediately.
2. Masked write: addr 7 holds 0x1234, write 0xABCD with mask 2'b10 -> read returns 0xAB34.
3. Collision: addr 3 holds 0x0000, same-edge read+write 0x5A5A mask 2'b01 -> bypass_p=1 returns 0x005A, bypass_p=0 returns 0x0000. Next read of addr 3 returns 0x005A in both builds.
4. Clear sweep (depth_p=16): fill all entries with 0xFFFF, pulse clear_i -> busy_o high exactly 16 cycles. A write of 0x1111 and a read issued during busy produce no effect and no rd_valid_o. Afterwards all 16 reads return 0x0000.
5. Reset mid-clear (depth_p=16): fill with 0xFFFF, pulse clear_i, drop reset_i after 6 busy cycles -> busy_o=0 immediately. Entries 0-5 read 0x0000, entries 6-15 read 0xFFFF.
6. Streaming and range: 8 back-to-back reads at rd_latency_p=2 -> 8 consecutive rd_valid_o cycles with in-order data. depth_p=12: read addr 13 returns 0 with rd_valid_o=1; write addr 13 leaves all entries unchanged.
